// File: rtl/ble_access_address_sync_if.sv
// Bit-stream input, configuration and octet output bundle for the BLE access-address sync block.
interface ble_access_address_sync_if #(
  parameter int unsigned OCTET_CNT_WIDTH = 8
);
  logic                       start;
  logic [31:0]                access_address;
  logic [OCTET_CNT_WIDTH-1:0] num_octet_to_capture;
  logic                       phy_bit;
  logic                       bit_valid;
  logic                       busy;
  logic                       hit_flag;
  logic [7:0]                 octet;
  logic                       octet_valid;
  logic                       capture_done;

  modport master (
    output start, access_address, num_octet_to_capture, phy_bit, bit_valid,
    input  busy, hit_flag, octet, octet_valid, capture_done
  );

  modport slave (
    input  start, access_address, num_octet_to_capture, phy_bit, bit_valid,
    output busy, hit_flag, octet, octet_valid, capture_done
  );
endinterface

// File: rtl/ble_access_address_sync.sv
// Searches the demodulated bit stream for a BLE access address (with Hamming tolerance)
// and then captures a programmed number of LSB-first octets for dewhitening/CRC.
module ble_access_address_sync #(
  parameter int unsigned MAX_BIT_ERR     = 0,
  parameter int unsigned OCTET_CNT_WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  ble_access_address_sync_if.slave bus
);

  localparam int unsigned AA_W     = 32;
  localparam int unsigned FILL_W   = 6;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned BITCNT_W = 3;
  localparam int unsigned CNT_W    = OCTET_CNT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [AA_W-1:0]     aa_q, aa_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [AA_W-1:0]     win_q, win_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [BYTE_W-1:0]   obyte_q, obyte_d;
  logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    octet_cnt_q, octet_cnt_d;
  logic                busy_q, busy_d;
  logic                hit_q, hit_d;
  logic [BYTE_W-1:0]   octet_q, octet_d;
  logic                octet_valid_q, octet_valid_d;
  logic                capture_done_q, capture_done_d;

  logic [AA_W-1:0]     win_shift;
  logic [BYTE_W-1:0]   obyte_shift;
  logic                aa_match;
  logic                octet_last;

  function automatic int unsigned popcount32(input logic [AA_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < AA_W; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  // The match looks at the window including the bit arriving this cycle.
  assign win_shift   = {bus.phy_bit, win_q[AA_W-1:1]};
  assign obyte_shift = {bus.phy_bit, obyte_q[BYTE_W-1:1]};
  assign aa_match    = (fill_q >= FILL_W'(AA_W - 1)) &&
                       (popcount32(win_shift ^ aa_q) <= MAX_BIT_ERR);
  assign octet_last  = (octet_cnt_q + CNT_W'(1)) == num_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      aa_q           <= '0;
      num_q          <= '0;
      win_q          <= '0;
      fill_q         <= '0;
      obyte_q        <= '0;
      bit_cnt_q      <= '0;
      octet_cnt_q    <= '0;
      busy_q         <= 1'b0;
      hit_q          <= 1'b0;
      octet_q        <= '0;
      octet_valid_q  <= 1'b0;
      capture_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      aa_q           <= aa_d;
      num_q          <= num_d;
      win_q          <= win_d;
      fill_q         <= fill_d;
      obyte_q        <= obyte_d;
      bit_cnt_q      <= bit_cnt_d;
      octet_cnt_q    <= octet_cnt_d;
      busy_q         <= busy_d;
      hit_q          <= hit_d;
      octet_q        <= octet_d;
      octet_valid_q  <= octet_valid_d;
      capture_done_q <= capture_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    aa_d           = aa_q;
    num_d          = num_q;
    win_d          = win_q;
    fill_d         = fill_q;
    obyte_d        = obyte_q;
    bit_cnt_d      = bit_cnt_q;
    octet_cnt_d    = octet_cnt_q;
    octet_d        = octet_q;
    hit_d          = 1'b0;
    octet_valid_d  = 1'b0;
    capture_done_d = 1'b0;

    // start wins in every state; a bit_valid in the same cycle is dropped.
    if (bus.start) begin
      aa_d        = bus.access_address;
      num_d       = bus.num_octet_to_capture;
      win_d       = '0;
      fill_d      = '0;
      obyte_d     = '0;
      bit_cnt_d   = '0;
      octet_cnt_d = '0;
      state_d     = ST_SEARCH;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_SEARCH: begin
          if (bus.bit_valid) begin
            win_d = win_shift;
            if (fill_q != FILL_W'(AA_W)) begin
              fill_d = fill_q + FILL_W'(1);
            end
            if (aa_match) begin
              hit_d = 1'b1;
              if (num_q == '0) begin
                capture_done_d = 1'b1;
                state_d        = ST_IDLE;
              end else begin
                obyte_d     = '0;
                bit_cnt_d   = '0;
                octet_cnt_d = '0;
                state_d     = ST_CAPTURE;
              end
            end
          end
        end
        ST_CAPTURE: begin
          if (bus.bit_valid) begin
            obyte_d   = obyte_shift;
            bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
            if (bit_cnt_q == BITCNT_W'(BYTE_W - 1)) begin
              octet_d       = obyte_shift;
              octet_valid_d = 1'b1;
              octet_cnt_d   = octet_cnt_q + CNT_W'(1);
              bit_cnt_d     = '0;
              if (octet_last) begin
                capture_done_d = 1'b1;
                state_d        = ST_IDLE;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.busy         = busy_q;
  assign bus.hit_flag     = hit_q;
  assign bus.octet        = octet_q;
  assign bus.octet_valid  = octet_valid_q;
  assign bus.capture_done = capture_done_q;

endmodule

// File: tb/tb_ble_access_address_sync.sv
// Scoreboard bench: three instances (MAX_BIT_ERR = 0, 1, 2) share one stimulus stream;
// expected events are queued per instance and popped by a monitor on every output pulse.
module tb_ble_access_address_sync;

  localparam int unsigned NDUT = 3;
  localparam int unsigned CW   = 8;
  localparam logic [31:0] AA       = 32'h8E89_BED6;
  localparam logic [31:0] AA_ERR2  = 32'h8E88_BEC6;
  localparam logic [31:0] AA_NEW   = 32'h5A3C_96E1;

  typedef struct packed {
    logic        hit;
    logic        ov;
    logic        done;
    logic [7:0]  oct;
    logic [31:0] cyc;
  } exp_t;

  logic          clk     = 1'b0;
  logic          rst     = 1'b0;
  logic          start_r = 1'b0;
  logic [31:0]   aa_r    = '0;
  logic [CW-1:0] num_r   = '0;
  logic          bit_r   = 1'b0;
  logic          bv_r    = 1'b0;
  logic [31:0]   cyc     = '0;
  logic [11:0]   outs_w [NDUT];
  int            errors  = 0;
  int            checks  = 0;
  exp_t          exp_q [NDUT][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ble_access_address_sync_if #(.OCTET_CNT_WIDTH(CW)) bus ();
    assign bus.start                = start_r;
    assign bus.access_address       = aa_r;
    assign bus.num_octet_to_capture = num_r;
    assign bus.phy_bit              = bit_r;
    assign bus.bit_valid            = bv_r;
    ble_access_address_sync #(.MAX_BIT_ERR(g), .OCTET_CNT_WIDTH(CW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign outs_w[g] = {bus.busy, bus.hit_flag, bus.octet_valid, bus.capture_done, bus.octet};
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic check_busy(input string name, input logic [NDUT-1:0] req);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("%s_busy_dut%0d", name, d), 32'(outs_w[d][11]), 32'(req[d]));
    end
  endtask

  task automatic drive(input logic s, input logic bv, input logic b);
    start_r = s;
    bv_r    = bv;
    bit_r   = b;
    @(negedge clk);
  endtask

  // Queue an event that must appear right after the next active edge.
  task automatic expect_evt(input logic [NDUT-1:0] mask, input logic h, input logic ov,
                            input logic dn, input logic [7:0] o);
    exp_t e;
    e.hit  = h;
    e.ov   = ov;
    e.done = dn;
    e.oct  = o;
    e.cyc  = cyc + 32'd1;
    for (int d = 0; d < NDUT; d++) begin
      if (mask[d]) exp_q[d].push_back(e);
    end
  endtask

  task automatic arm(input logic [31:0] a, input logic [CW-1:0] n, input logic bv, input logic b);
    aa_r  = a;
    num_r = n;
    drive(1'b1, bv, b);
  endtask

  task automatic tx_bit(input logic b, input int gap);
    drive(1'b0, 1'b1, b);
    repeat (gap) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic tx_aa(input logic [31:0] w, input int gap, input logic [NDUT-1:0] hit_mask,
                       input logic dn);
    for (int i = 0; i < 32; i++) begin
      if (i == 31 && hit_mask != '0) expect_evt(hit_mask, 1'b1, 1'b0, dn, 8'h00);
      tx_bit(w[i], gap);
    end
  endtask

  task automatic tx_octet(input logic [7:0] o, input int gap, input logic last, input logic expect_it);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && expect_it) expect_evt('1, 1'b0, 1'b1, last, o);
      tx_bit(o[i], gap);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int d = 0; d < NDUT; d++) begin
          if (outs_w[d][10:8] != 3'b000) begin
            checks++;
            if (exp_q[d].size() == 0) begin
              errors++;
              $display("FAIL unexpected_event dut%0d: got hit=%b ov=%b done=%b octet=%h cyc=%0d, required no event",
                       d, outs_w[d][10], outs_w[d][9], outs_w[d][8], outs_w[d][7:0], cyc);
            end else begin
              e = exp_q[d].pop_front();
              if (outs_w[d][10] !== e.hit || outs_w[d][9] !== e.ov || outs_w[d][8] !== e.done ||
                  (e.ov && outs_w[d][7:0] !== e.oct) || cyc !== e.cyc) begin
                errors++;
                $display("FAIL event dut%0d: got hit=%b ov=%b done=%b octet=%h cyc=%0d, required hit=%b ov=%b done=%b octet=%h cyc=%0d",
                         d, outs_w[d][10], outs_w[d][9], outs_w[d][8], outs_w[d][7:0], cyc,
                         e.hit, e.ov, e.done, e.oct, e.cyc);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    logic [7:0] b0a;
    b0a = 8'h0A;

    // Basic capture of two octets with continuous bit_valid.
    arm(AA, 8'd2, 1'b0, 1'b0);
    check_busy("t1_armed", 3'b111);
    tx_aa(AA, 0, 3'b111, 1'b0);
    tx_octet(8'h25, 0, 1'b0, 1'b1);
    tx_octet(8'h0A, 0, 1'b1, 1'b1);
    check_busy("t1_end", 3'b000);

    // Noise prefix and sparse bit_valid.
    arm(AA, 8'd2, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) tx_bit(1'($urandom_range(1, 0)), 3);
    tx_aa(AA, 3, 3'b111, 1'b0);
    tx_octet(8'h25, 3, 1'b0, 1'b1);
    tx_octet(8'h0A, 3, 1'b1, 1'b1);
    check_busy("t2_end", 3'b000);

    // Two bit errors: only the tolerance-2 instance hits.
    arm(AA, 8'd0, 1'b0, 1'b0);
    tx_aa(AA_ERR2, 0, 3'b100, 1'b1);
    check_busy("t3_end", 3'b011);

    // A bit_valid on the start cycle is not consumed.
    arm(AA, 8'd0, 1'b1, AA[0]);
    for (int i = 1; i < 32; i++) tx_bit(AA[i], 0);
    check_busy("t4_nohit", 3'b111);
    // Zero-octet capture: hit and done together, then idle.
    arm(AA, 8'd0, 1'b0, 1'b0);
    tx_aa(AA, 0, 3'b111, 1'b1);
    check_busy("t4_done", 3'b000);
    tx_aa(AA, 0, 3'b000, 1'b0);
    check_busy("t4_idle", 3'b000);

    // Restart after 12 captured bits, then a new configuration.
    arm(AA, 8'd2, 1'b0, 1'b0);
    tx_aa(AA, 0, 3'b111, 1'b0);
    tx_octet(8'h25, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tx_bit(b0a[i], 0);
    arm(AA_NEW, 8'd1, 1'b0, 1'b0);
    check_busy("t5_rearm", 3'b111);
    tx_aa(AA_NEW, 0, 3'b111, 1'b0);
    tx_octet(8'hC3, 0, 1'b1, 1'b1);
    check_busy("t5_end", 3'b000);

    // Asynchronous reset between bit_valid pulses during capture.
    arm(AA, 8'd2, 1'b0, 1'b0);
    tx_aa(AA, 1, 3'b111, 1'b0);
    tx_octet(8'h25, 1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tx_bit(b0a[i], 1);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) check($sformatf("t6_async_rst_outs_dut%0d", d), 32'(outs_w[d]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    tx_aa(AA, 0, 3'b000, 1'b0);
    tx_octet(8'h0A, 0, 1'b0, 1'b0);
    check_busy("t6_after_rst", 3'b000);

    repeat (4) drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) check($sformatf("reset_outs_dut%0d", d), 32'(outs_w[d]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) check($sformatf("post_reset_outs_dut%0d", d), 32'(outs_w[d]), 32'd0);

    fork
      monitor();
      stimulus();
    join_any
    disable fork;

    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("pending_events_dut%0d", d), 32'(exp_q[d].size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ble_access_address_sync.md
Name: ble_access_address_sync

Overview:
- Consumes the hard-decision bit stream (phy_bit/bit_valid) from the GFSK demodulator.
- Searches for a programmable 32-bit BLE access address, allowing a configurable Hamming-distance tolerance.
- On a hit, captures a programmed number of following octets, assembled LSB-first, and presents them to the downstream dewhitening/CRC stage.

Parameters:
- MAX_BIT_ERR, 0, maximum Hamming distance (0..31) between the received 32-bit window and access_address that still counts as a hit.
- OCTET_CNT_WIDTH, 8, width of the octet count input and internal octet counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- start  input  1  single-cycle pulse; latches configuration and (re)arms the search
- access_address  input  32  target access address; bit 0 is the first bit over the air; sampled on start
- num_octet_to_capture  input  OCTET_CNT_WIDTH  number of octets to capture after a hit; sampled on start
- phy_bit  input  1  demodulated bit
- bit_valid  input  1  qualifies phy_bit
- busy  output  1  high in SEARCH or CAPTURE
- hit_flag  output  1  one-cycle pulse on access-address match
- octet  output  8  captured octet; first received bit in octet[0]
- octet_valid  output  1  one-cycle pulse qualifying octet
- capture_done  output  1  one-cycle pulse when the final octet is delivered

Behaviour:
- Reset is asynchronous, active-high (rst); clock is clk. All outputs reset to 0, state resets to IDLE, all internal registers reset to 0.

State machine, three states:

IDLE:
- busy=0; phy_bit/bit_valid are ignored.
- start -> latch access_address and num_octet_to_capture into internal registers, clear the window shift register and fill counter, go to SEARCH.

SEARCH:
- On each bit_valid, shift the window: win <= {phy_bit, win[31:1]}.
- The fill counter saturates at 32. A match is evaluated only when the fill count (including the current bit) is >= 32.
- Match = popcount(win_next XOR aa_latched) <= MAX_BIT_ERR. Evaluate it combinationally on the next window value and register it on the same edge, so hit_flag is high in the cycle after the bit_valid cycle that completed the match.
- On a hit with num_octet_to_capture > 0: go to CAPTURE and clear the bit and octet counters.
- On a hit with num_octet_to_capture = 0: assert capture_done in the same cycle as hit_flag and go to IDLE.

CAPTURE:
- On each bit_valid: obyte <= {phy_bit, obyte[7:1]} and bit_cnt++.
- On the 8th bit, register the assembled byte (including the current bit) into octet and pulse octet_valid in the next cycle. Then increment octet_cnt and reset bit_cnt to 0.
- When octet_cnt reaches the latched count, capture_done pulses in the same cycle as the final octet_valid, and the state goes to IDLE.
- The window is not searched during CAPTURE; a second access address inside the payload raises no hit.

Outputs and edge cases:
- octet holds its last value between pulses.
- hit_flag, octet_valid and capture_done are single-cycle pulses, each 0 unless stated above.
- A bit_valid that falls in the same cycle as start is not consumed.
- start in SEARCH or CAPTURE aborts the current operation and restarts SEARCH with new configuration. The fill counter is cleared, partial octets are discarded, and no capture_done is issued.
- bit_valid gaps of any length are allowed; the counters advance only on bit_valid.
- rst mid-capture returns the block to IDLE immediately with all outputs 0.
- Throughput is one bit per clock (bit_valid may be continuously high).

Test Plan:
1. start with AA=0x8E89BED6, num=2, MAX_BIT_ERR=0; feed AA LSB-first then bits of 0x25, 0x0A LSB-first, bit_valid continuous -> hit_flag one cycle after the 32nd AA bit; octet_valid with 0x25 then 0x0A; capture_done coincident with 0x0A; busy falls.
2. Same stream preceded by 100 random bits and with bit_valid every 4th clock -> identical octets; hit_flag exactly one clock after the qualifying bit_valid.
3. AA with 2 bit errors: MAX_BIT_ERR=1 -> no hit, busy stays 1; MAX_BIT_ERR=2 -> hit.
4. num=0 -> hit_flag and capture_done in the same cycle; no octet_valid; IDLE next cycle.
5. start re-pulsed after 12 captured bits -> no octet_valid/capture_done; a fresh AA must be received before a new hit.
6. rst asserted during CAPTURE, between bit_valid pulses -> all outputs 0 asynchronously; bits after rst release are ignored until start.
